// File: rtl/cv32e40p_tmr_fault_monitor.sv
// cv32e40p_tmr_fault_monitor
// Consumes the per-replica disagreement flags of the TMR multiplier voters.
// It classifies each replica's errors as transient or permanent, keeps
// saturating transient counters, and offers fault events over valid/ready.
// Optional feature: define CV32E40P_TMR_FAULT_IRQ_EN to build the irq_o level.
module cv32e40p_tmr_fault_monitor #(
    parameter int NUM_VOTERS  = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int PERM_THRESH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [NUM_VOTERS-1:0]  err_a_i,
    input  logic [NUM_VOTERS-1:0]  err_b_i,
    input  logic [NUM_VOTERS-1:0]  err_c_i,
    input  logic                   clear_i,
    output logic                   report_valid_o,
    input  logic                   report_ready_i,
    output logic [1:0]             report_replica_o,
    output logic                   report_perm_o,
    output logic                   report_ovf_o,
    output logic [2:0]             replica_faulty_o,
    output logic [3*CNT_WIDTH-1:0] trans_cnt_o,
    output logic                   multi_fault_o,
    output logic                   irq_o
);

    localparam int RUN_W = $clog2(PERM_THRESH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULTY} state_t;

    state_t               r_state     [3];
    state_t               w_state_nxt [3];
    logic [RUN_W-1:0]     r_run       [3];
    logic [RUN_W-1:0]     w_run_nxt   [3];
    logic [CNT_WIDTH-1:0] r_cnt       [3];
    logic [CNT_WIDTH-1:0] w_cnt_nxt   [3];

    // Pending bits: [2:0] permanent per replica, [5:3] transient per replica.
    // The index order is also the report priority (lowest index wins).
    logic [5:0] r_pend;
    logic [5:0] w_pend_nxt;
    logic [5:0] w_set;
    logic [5:0] w_sel;
    logic [5:0] w_consume;

    logic       r_ovf;
    logic       w_ovf_nxt;
    logic       r_mf;
    logic       w_mf_nxt;
    logic [2:0] w_rep_err;
    logic [2:0] w_faulty_nxt;
    logic       w_vote_clash;

    // Qualified per-replica error and same-voter disagreement of two replicas.
    assign w_rep_err[0] = valid_i & (|err_a_i);
    assign w_rep_err[1] = valid_i & (|err_b_i);
    assign w_rep_err[2] = valid_i & (|err_c_i);
    assign w_vote_clash = valid_i &
        (|((err_a_i & err_b_i) | (err_a_i & err_c_i) | (err_b_i & err_c_i)));

    // Per-replica next state, run length, transient counter and new events.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_set = '0;
        for (int r = 0; r < 3; r++) begin
            w_state_nxt[r]  = r_state[r];
            w_run_nxt[r]    = r_run[r];
            w_cnt_nxt[r]    = r_cnt[r];
            w_faulty_nxt[r] = 1'b0;
            unique case (r_state[r])
                ST_OK: begin
                    if (w_rep_err[r]) begin
                        w_state_nxt[r] = ST_SUSPECT;
                        w_run_nxt[r]   = RUN_W'(1);
                    end
                end
                ST_SUSPECT: begin
                    if (w_rep_err[r]) begin
                        if (r_run[r] == RUN_W'(PERM_THRESH - 1)) begin
                            w_state_nxt[r] = ST_FAULTY;
                            w_run_nxt[r]   = '0;
                            w_set[r]       = 1'b1;
                        end else begin
                            w_run_nxt[r] = r_run[r] + 1'b1;
                        end
                    end else if (valid_i) begin
                        // A clean qualified cycle ends the run: it was transient.
                        w_state_nxt[r] = ST_OK;
                        w_run_nxt[r]   = '0;
                        w_set[3 + r]   = 1'b1;
                        if (r_cnt[r] != CNT_MAX) begin
                            w_cnt_nxt[r] = r_cnt[r] + 1'b1;
                        end
                    end
                end
                default: begin
                    // FAULTY is sticky; further errors are ignored.
                end
            endcase
            w_faulty_nxt[r] = (w_state_nxt[r] == ST_FAULTY);
        end
    end

    // Fixed-priority one-hot selection of the offered pending bit.
    always_comb begin
        w_sel = '0;
        for (int i = 5; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel    = '0;
                w_sel[i] = 1'b1;
            end
        end
    end

    // A re-set on the transfer edge keeps the bit and is not an overflow.
    assign w_consume  = w_sel & {6{report_ready_i}};
    assign w_pend_nxt = (r_pend & ~w_consume) | w_set;
    assign w_ovf_nxt  = r_ovf | (|(w_set & r_pend & ~w_consume));
    assign w_mf_nxt   = r_mf | w_vote_clash |
        (w_faulty_nxt[0] & w_faulty_nxt[1]) |
        (w_faulty_nxt[0] & w_faulty_nxt[2]) |
        (w_faulty_nxt[1] & w_faulty_nxt[2]);

    // State registers; clear has the same effect as reset and wins over events.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            // NOTE: the per-replica arrays are three flops each, not a RAM,
            // so they are reset like any other register.
            for (int r = 0; r < 3; r++) begin
                r_state[r] <= ST_OK;
                r_run[r]   <= '0;
                r_cnt[r]   <= '0;
            end
            r_pend <= '0;
            r_ovf  <= 1'b0;
            r_mf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            for (int r = 0; r < 3; r++) begin
                r_state[r] <= w_state_nxt[r];
                r_run[r]   <= w_run_nxt[r];
                r_cnt[r]   <= w_cnt_nxt[r];
            end
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
            r_mf   <= w_mf_nxt;
        end
    end

    // Outputs decoded only from registers.
    always_comb begin
        replica_faulty_o = '0;
        trans_cnt_o      = '0;
        for (int r = 0; r < 3; r++) begin
            replica_faulty_o[r]                      = (r_state[r] == ST_FAULTY);
            trans_cnt_o[r*CNT_WIDTH +: CNT_WIDTH]    = r_cnt[r];
        end
    end

    assign report_valid_o   = |r_pend;
    assign report_perm_o    = |w_sel[2:0];
    assign report_replica_o = {w_sel[2] | w_sel[5], w_sel[1] | w_sel[4]};
    assign report_ovf_o     = r_ovf;
    assign multi_fault_o    = r_mf;

`ifdef CV32E40P_TMR_FAULT_IRQ_EN
    logic r_irq;

    // Interrupt level: any permanent event pending or majority lost.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (|w_pend_nxt[2:0]) | w_mf_nxt;
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Self-checking bench for cv32e40p_tmr_fault_monitor: a directed vector
// table, hand-written corner sequences and randomized traffic, all compared
// cycle by cycle against a behavioural model.
module tb_cv32e40p_tmr_fault_monitor;

    localparam int CW  = 8;
    localparam int PT  = 3;
    localparam int CMX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    logic [3:0]    err_a_i;
    logic [3:0]    err_b_i;
    logic [3:0]    err_c_i;
    logic          clear_i;
    logic          report_valid_o;
    logic          report_ready_i;
    logic [1:0]    report_replica_o;
    logic          report_perm_o;
    logic          report_ovf_o;
    logic [2:0]    replica_faulty_o;
    logic [3*CW-1:0] trans_cnt_o;
    logic          multi_fault_o;
    logic          irq_o;

    cv32e40p_tmr_fault_monitor #(
        .NUM_VOTERS (4),
        .CNT_WIDTH  (CW),
        .PERM_THRESH(PT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .err_a_i         (err_a_i),
        .err_b_i         (err_b_i),
        .err_c_i         (err_c_i),
        .clear_i         (clear_i),
        .report_valid_o  (report_valid_o),
        .report_ready_i  (report_ready_i),
        .report_replica_o(report_replica_o),
        .report_perm_o   (report_perm_o),
        .report_ovf_o    (report_ovf_o),
        .replica_faulty_o(replica_faulty_o),
        .trans_cnt_o     (trans_cnt_o),
        .multi_fault_o   (multi_fault_o),
        .irq_o           (irq_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // run == 0 means healthy, run > 0 means a run of errors is in progress.
    int m_run    [3];
    bit m_faulty [3];
    int m_cnt    [3];
    bit m_pp     [3];
    bit m_pt     [3];
    bit m_ovf, m_mf, m_irq;

    task automatic model_reset();
        for (int r = 0; r < 3; r++) begin
            m_run[r] = 0; m_faulty[r] = 0; m_cnt[r] = 0; m_pp[r] = 0; m_pt[r] = 0;
        end
        m_ovf = 0; m_mf = 0; m_irq = 0;
    endtask

    task automatic model_offer(output bit v, output int rep, output bit perm);
        v = 0; rep = 0; perm = 0;
        for (int r = 2; r >= 0; r--) if (m_pt[r]) begin v = 1; rep = r; perm = 0; end
        for (int r = 2; r >= 0; r--) if (m_pp[r]) begin v = 1; rep = r; perm = 1; end
    endtask

    task automatic model_step(input bit vld, input logic [3:0] a, b, c,
                              input bit clr, rdy, rst);
        bit v, sp, xfer;
        int srep, nfaulty;
        bit np [3];
        bit nt [3];
        logic [3:0] e [3];
        if (!rst || clr) begin
            model_reset();
            return;
        end
        model_offer(v, srep, sp);
        xfer = v && rdy;
        e[0] = a; e[1] = b; e[2] = c;
        for (int r = 0; r < 3; r++) begin
            bit err;
            np[r] = 0; nt[r] = 0;
            err = vld && (e[r] != 0);
            if (m_faulty[r]) begin
            end else if (m_run[r] == 0) begin
                if (err) m_run[r] = 1;
            end else if (err) begin
                m_run[r]++;
                if (m_run[r] >= PT) begin m_faulty[r] = 1; m_run[r] = 0; np[r] = 1; end
            end else if (vld) begin
                m_run[r] = 0;
                if (m_cnt[r] < CMX) m_cnt[r]++;
                nt[r] = 1;
            end
        end
        if (vld)
            for (int i = 0; i < 4; i++)
                if (int'(a[i]) + int'(b[i]) + int'(c[i]) >= 2) m_mf = 1;
        nfaulty = int'(m_faulty[0]) + int'(m_faulty[1]) + int'(m_faulty[2]);
        if (nfaulty >= 2) m_mf = 1;
        for (int r = 0; r < 3; r++) begin
            bit cp, ct;
            cp = xfer && sp && (srep == r);
            ct = xfer && !sp && (srep == r);
            if (np[r]) begin if (m_pp[r] && !cp) m_ovf = 1; m_pp[r] = 1; end
            else if (cp) m_pp[r] = 0;
            if (nt[r]) begin if (m_pt[r] && !ct) m_ovf = 1; m_pt[r] = 1; end
            else if (ct) m_pt[r] = 0;
        end
`ifdef CV32E40P_TMR_FAULT_IRQ_EN
        m_irq = m_pp[0] || m_pp[1] || m_pp[2] || m_mf;
`else
        m_irq = 0;
`endif
    endtask

    task automatic compare_model();
        bit v, p;
        int rep;
        logic [23:0] ecnt;
        model_offer(v, rep, p);
        ecnt = {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
        check("report_valid",   report_valid_o,   v);
        check("report_replica", report_replica_o, rep);
        check("report_perm",    report_perm_o,    p);
        check("report_ovf",     report_ovf_o,     m_ovf);
        check("replica_faulty", replica_faulty_o, {m_faulty[2], m_faulty[1], m_faulty[0]});
        check("trans_cnt",      trans_cnt_o,      ecnt);
        check("multi_fault",    multi_fault_o,    m_mf);
        check("irq",            irq_o,            m_irq);
    endtask

    // One clock: drive, advance the model, take the edge, sample 1 ns later.
    task automatic cycle(input bit vld, input logic [3:0] a, b, c,
                         input bit clr, rdy, rst);
        valid_i = vld; err_a_i = a; err_b_i = b; err_c_i = c;
        clear_i = clr; report_ready_i = rdy; rst_n = rst;
        model_step(vld, a, b, c, clr, rdy, rst);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 4'h0, 4'h0, 4'h0, 0, rdy, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        vld;
        logic [3:0]  a, b, c;
        logic        clr, rdy, rst;
        logic        e_valid;
        logic [1:0]  e_rep;
        logic        e_perm;
        logic [2:0]  e_faulty;
        logic [23:0] e_cnt;
        logic        e_mf;
    } vec_t;

    function automatic vec_t mk(logic vld, logic [3:0] a, b, c, logic clr, rdy, rst,
                                logic ev, logic [1:0] erep, logic eperm,
                                logic [2:0] ef, logic [23:0] ecnt, logic emf);
        vec_t t;
        t.vld = vld; t.a = a; t.b = b; t.c = c; t.clr = clr; t.rdy = rdy; t.rst = rst;
        t.e_valid = ev; t.e_rep = erep; t.e_perm = eperm;
        t.e_faulty = ef; t.e_cnt = ecnt; t.e_mf = emf;
        return t;
    endfunction

    vec_t tbl [12];

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0; report_ready_i = 1'b0;
        err_a_i = '0; err_b_i = '0; err_c_i = '0;
        model_reset();

        //            vld a      b      c      clr rdy rst   v  rep p  faulty  cnt         mf
        tbl[0]  = mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 0, 3'b000, 24'h000000, 0); // reset
        tbl[1]  = mk(1, 4'h0, 4'h1, 4'h0, 0, 0, 1,  0, 0, 0, 3'b000, 24'h000000, 0); // r1 suspect
        tbl[2]  = mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 1,  1, 1, 0, 3'b000, 24'h000100, 0); // r1 transient
        tbl[3]  = mk(0, 4'h0, 4'h0, 4'h0, 0, 1, 1,  0, 0, 0, 3'b000, 24'h000100, 0); // accepted
        tbl[4]  = mk(1, 4'h1, 4'h0, 4'h0, 0, 0, 1,  0, 0, 0, 3'b000, 24'h000100, 0); // r0 run 1
        tbl[5]  = mk(1, 4'h1, 4'h0, 4'h0, 0, 0, 1,  0, 0, 0, 3'b000, 24'h000100, 0); // r0 run 2
        tbl[6]  = mk(0, 4'h1, 4'h0, 4'h0, 0, 0, 1,  0, 0, 0, 3'b000, 24'h000100, 0); // gap
        tbl[7]  = mk(1, 4'h1, 4'h0, 4'h0, 0, 0, 1,  1, 0, 1, 3'b001, 24'h000100, 0); // r0 faulty
        tbl[8]  = mk(1, 4'h1, 4'h0, 4'h0, 0, 0, 1,  1, 0, 1, 3'b001, 24'h000100, 0); // ignored
        tbl[9]  = mk(1, 4'h4, 4'h0, 4'h4, 0, 0, 1,  1, 0, 1, 3'b001, 24'h000100, 1); // majority lost
        tbl[10] = mk(0, 4'h0, 4'h0, 4'h0, 1, 0, 1,  0, 0, 0, 3'b000, 24'h000000, 0); // clear
        tbl[11] = mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 1,  0, 0, 0, 3'b000, 24'h000000, 0);

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr, tbl[i].rdy, tbl[i].rst);
            check($sformatf("tbl%0d_valid", i),  report_valid_o,   tbl[i].e_valid);
            check($sformatf("tbl%0d_rep", i),    report_replica_o, tbl[i].e_rep);
            check($sformatf("tbl%0d_perm", i),   report_perm_o,    tbl[i].e_perm);
            check($sformatf("tbl%0d_faulty", i), replica_faulty_o, tbl[i].e_faulty);
            check($sformatf("tbl%0d_cnt", i),    trans_cnt_o,      tbl[i].e_cnt);
            check($sformatf("tbl%0d_mf", i),     multi_fault_o,    tbl[i].e_mf);
        end

        // Priority under backpressure: transient r2 pending, then permanent r1.
        cycle(1, 4'h0, 4'h0, 4'h2, 1, 0, 1);
        cycle(1, 4'h0, 4'h0, 4'h2, 0, 0, 1);
        cycle(1, 4'h0, 4'h0, 4'h0, 0, 0, 1);
        for (int k = 0; k < PT; k++) cycle(1, 4'h0, 4'h8, 4'h0, 0, 0, 1);
        check("prio_first_rep",  report_replica_o, 2'd1);
        check("prio_first_perm", report_perm_o,    1'b1);
        idle(1);
        check("prio_second_valid", report_valid_o,   1'b1);
        check("prio_second_rep",   report_replica_o, 2'd2);
        check("prio_second_perm",  report_perm_o,    1'b0);
        idle(1);
        check("prio_drained", report_valid_o, 1'b0);

        // Overflow and saturation: 300 transients on r0, never accepted.
        cycle(0, 4'h0, 4'h0, 4'h0, 1, 0, 1);
        for (int k = 0; k < 300; k++) begin
            cycle(1, 4'h3, 4'h0, 4'h0, 0, 0, 1);
            cycle(1, 4'h0, 4'h0, 4'h0, 0, 0, 1);
        end
        check("sat_ovf", report_ovf_o, 1'b1);
        check("sat_cnt", trans_cnt_o[7:0], 8'd255);

        // Reset mid-run: r0 at run 2, one reset cycle discards it.
        cycle(0, 4'h0, 4'h0, 4'h0, 1, 0, 1);
        cycle(1, 4'h1, 4'h0, 4'h0, 0, 0, 1);
        cycle(1, 4'h1, 4'h0, 4'h0, 0, 0, 1);
        cycle(1, 4'h1, 4'h0, 4'h0, 0, 0, 0);
        cycle(1, 4'h0, 4'h0, 4'h0, 0, 0, 1);
        check("rstmid_valid", report_valid_o, 1'b0);
        check("rstmid_cnt",   trans_cnt_o,    24'h0);
        cycle(1, 4'h1, 4'h0, 4'h0, 0, 0, 1);
        cycle(1, 4'h1, 4'h0, 4'h0, 0, 0, 1);
        check("rstmid_not_faulty", replica_faulty_o, 3'b000);
        cycle(1, 4'h1, 4'h0, 4'h0, 0, 0, 1);
        check("rstmid_faulty", replica_faulty_o, 3'b001);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] ra, rb, rc;
            ra = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cycle(1'($urandom_range(0, 3) != 0), ra, rb, rc,
                  1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 299) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40p_tmr_fault_monitor.md
# cv32e40p_tmr_fault_monitor

Consumer for the per-replica disagreement flags produced by the TMR voters around the triplicated multiplier. It classifies each replica's disagreements as transient or permanent and keeps saturating transient counters. Events are reported to a CSR/debug agent through a valid/ready handshake, with an optional interrupt. It sits beside the TMR multiplier wrapper in the EX stage and is fed by the `error_detected_input_a/b/c` outputs of every voter.

## Interface
- `NUM_VOTERS`, 4: number of voters feeding the monitor (result, multicycle, mulh_active, ready).
- `CNT_WIDTH`, 8: width of each per-replica transient counter.
- `PERM_THRESH`, 3: consecutive qualified error cycles that declare a replica permanently faulty. Must be at least 2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  error flags are qualified this cycle (multiplier enabled).
- `err_a_i`  in  NUM_VOTERS  per-voter flag: replica 0 disagrees with the voted value.
- `err_b_i`  in  NUM_VOTERS  same, replica 1.
- `err_c_i`  in  NUM_VOTERS  same, replica 2.
- `clear_i`  in  1  clears counters, states, pending events and sticky flags.
- `report_valid_o`  out  1  a fault event is offered.
- `report_ready_i`  in  1  the agent accepts the event.
- `report_replica_o`  out  2  replica index of the offered event (0..2).
- `report_perm_o`  out  1  offered event kind: 1 = permanent, 0 = transient.
- `report_ovf_o`  out  1  sticky: an event was coalesced into an already-pending event.
- `replica_faulty_o`  out  3  per-replica permanent-fault flags.
- `trans_cnt_o`  out  3*CNT_WIDTH  transient counters; replica r occupies bits [r*CNT_WIDTH +: CNT_WIDTH].
- `multi_fault_o`  out  1  sticky: majority lost or not attributable.
- `irq_o`  out  1  interrupt. Only driven when the IRQ feature is compiled in; see Configuration.

## Operation
- Replica error: `rep_err[r] = valid_i & |err_r_i`.
- Each replica has its own FSM with states OK, SUSPECT and FAULTY, plus a run counter.
  - OK: if `rep_err`, go to SUSPECT and set run = 1.
  - SUSPECT with `rep_err`: run increments. When run reaches PERM_THRESH, go to FAULTY and set a permanent-pending bit.
  - SUSPECT with `valid_i` = 1 and no `rep_err`: go to OK. The transient counter increments, saturating at 2^CNT_WIDTH-1, and a transient-pending bit is set.
  - SUSPECT with `valid_i` = 0: hold state and run count.
  - FAULTY: sticky until `clear_i` or reset. Further errors from that replica are ignored.
- `replica_faulty_o[r]` = 1 exactly when replica r is in FAULTY.
- There are 6 pending bits: 3 replicas × 2 kinds. Setting a bit that is already set (and not being consumed in the same cycle) sets `report_ovf_o`.
- Report selection is fixed priority: all permanent bits before any transient bit, then lowest replica index first.
  - `report_valid_o` = OR of all pending bits.
  - `report_replica_o` and `report_perm_o` show the selected bit; they are 0 when `report_valid_o` is 0.
  - The offered event is stable while `report_valid_o` is high and `report_ready_i` is low, unless a higher-priority bit arrives.
  - A transfer happens on an edge where `report_valid_o` and `report_ready_i` are both 1. It clears the selected bit.
  - If the same bit is set again on the same edge as its transfer, it stays set and `report_ovf_o` is not set.
- `multi_fault_o` is set on a qualified cycle when any single voter bit is flagged for two or more replicas. It is also set when two or more replicas are FAULTY. It is sticky.
- `clear_i` has the same effect as reset on all state, and takes priority over any simultaneous event.

## Timing
- All outputs are registered or decoded only from registers. There is no combinational path from inputs to outputs, except that `report_valid_o` and the event fields change only after an edge.
- An error event at edge k becomes visible on `report_valid_o` and `trans_cnt_o` after edge k, i.e. one-cycle latency.
- FAULTY is declared at the PERM_THRESH-th consecutive qualified error edge. Cycles with `valid_i` = 0 do not break the run.
- Reset and clear values:
  - every output 0;
  - all FSMs in OK;
  - run counters 0;
  - pending bits 0.
- Reset or clear in mid-run discards the partial run. No transient event is logged.

## Configuration
- `CV32E40P_TMR_FAULT_IRQ_EN` defined: `irq_o` is a registered level, high while any permanent-pending bit is set or `multi_fault_o` = 1.
- `CV32E40P_TMR_FAULT_IRQ_EN` undefined: `irq_o` is tied 0 and no IRQ logic is synthesized. All other behaviour is identical.

## Test plan
- Transient: `valid_i` = 1, `err_b_i` = 4'b0001 for 1 cycle, then 0 → replica 1 goes SUSPECT then OK; `trans_cnt_o[15:8]` = 1; an event is offered with replica = 1, perm = 0; `report_ready_i` = 1 clears it the next edge.
- Permanent: `err_a_i` = 4'b0001 on 3 consecutive qualified cycles with a `valid_i` = 0 gap between the 2nd and 3rd → `replica_faulty_o` = 3'b001 after the 3rd; permanent event offered for replica 0; `irq_o` = 1 with the macro defined, 0 without.
- Priority/backpressure: transient on replica 2 pending with `report_ready_i` = 0, then permanent on replica 1 → replica 1 / perm = 1 is offered first, then replica 2 / perm = 0.
- Overflow and saturation: 300 transient events on replica 0 while never accepted → `report_ovf_o` = 1; `trans_cnt_o[7:0]` = 255.
- Majority loss: `err_a_i` = `err_c_i` = 4'b0100 in one qualified cycle → `multi_fault_o` = 1 after that edge and sticky; `clear_i` returns every output to 0.
- Reset mid-run: replica 0 in SUSPECT with run = 2, `rst_n` low for 1 cycle → state OK, counter 0, no event offered.
